rotor_shift_stage: RTL and testbench

- One rotor position of the Enigma datapath.
- Takes an uppercase ASCII letter and adds (forward) or subtracts (reverse) the rotor's current position, producing the non-truncated character value (NTCV).
- Wraps the NTCV back into A-Z using the overflow/underflow rule, registers the result, and advances the rotor position counter. It emits a carry pulse so the next rotor can step.

---
 rtl/enigma_pkg.sv | 22 ++
 rtl/letter_wrap.sv | 30 +++
 rtl/rotor_shift_stage.sv | 130 +++++++++++++
 tb/tb_rotor_shift_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared constants and helpers for the Enigma rotor datapath.
//               LETTER_A/LETTER_Z bound the uppercase ASCII range, ALPHA_LEN
//               is the alphabet size, POS_W is the rotor position width.
// Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

    localparam logic [7:0] LETTER_A  = 8'd65;
    localparam logic [7:0] LETTER_Z  = 8'd90;
    localparam int         ALPHA_LEN = 26;
    localparam int         POS_W     = 5;

    // True for uppercase ASCII 'A'..'Z'.
    function automatic logic is_letter(input logic [7:0] ch);
        return (ch >= LETTER_A) && (ch <= LETTER_Z);
    endfunction

endpackage : enigma_pkg
`default_nettype wire

// File: rtl/letter_wrap.sv
`default_nettype none
// ============================================================================
// Module      : letter_wrap
// Description : Folds a non-truncated character value (NTCV) back into A..Z.
//               Forward direction only checks overflow past 'Z', reverse
//               direction only checks underflow below 'A'.
// Ports       : ntcv    in  8  non-truncated character value
//               dir     in  1  0 = forward (added), 1 = reverse (subtracted)
//               wrapped out 8  letter folded into A..Z
// Revision    : 1.0 - initial release
// ============================================================================
module letter_wrap
    import enigma_pkg::*;
(
    input  logic [7:0] ntcv,
    input  logic       dir,
    output logic [7:0] wrapped
);

    always_comb begin
        wrapped = ntcv;
        if (!dir && (ntcv > LETTER_Z)) begin
            wrapped = ntcv - 8'(ALPHA_LEN);
        end else if (dir && (ntcv < LETTER_A)) begin
            wrapped = ntcv + 8'(ALPHA_LEN);
        end
    end

endmodule : letter_wrap
`default_nettype wire

// File: rtl/rotor_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : rotor_shift_stage
// Description : One rotor position of the Enigma datapath. Adds (forward) or
//               subtracts (reverse) the current rotor position from an ASCII
//               letter, wraps into A..Z, registers the result and advances
//               the rotor, emitting a carry pulse when leaving NOTCH.
//               Optional macro ROTOR_DOUBLE_STEP_EN: rotor also steps (and
//               carries) when sitting on NOTCH, reproducing the Enigma
//               double-step anomaly.
// Parameters  : NOTCH     position whose departure produces carry_out
//               INIT_POS  position loaded on reset
//               SELF_STEP 1 = step on every accepted letter
// Ports       : clock, resetn (async, active low)
//               in_valid/in_ready/in_letter/dir/step_in  input channel
//               load_en/load_pos                         position load
//               out_valid/out_ready/out_letter/carry_out output channel
//               rotor_pos                                current position
// Revision    : 1.0 - initial release
// ============================================================================
module rotor_shift_stage
    import enigma_pkg::*;
#(
    parameter logic [POS_W-1:0] NOTCH     = 5'd16,
    parameter logic [POS_W-1:0] INIT_POS  = 5'd0,
    parameter bit               SELF_STEP = 1'b0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_letter,
    input  logic             dir,
    input  logic             step_in,
    input  logic             load_en,
    input  logic [POS_W-1:0] load_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_letter,
    output logic             carry_out,
    output logic [POS_W-1:0] rotor_pos
);

    logic             alive;
    logic             accept;
    logic             letter_in;
    logic             step_req;
    logic             dbl_step;
    logic             load_ok;
    logic             carry_next;
    logic [7:0]       ntcv;
    logic [7:0]       wrapped;
    logic [7:0]       enc_letter;
    logic [POS_W-1:0] pos_next;

    // Holds in_ready low while reset is asserted and for the first cycle
    // after release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    assign in_ready  = alive && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign letter_in = is_letter(in_letter);

    // Encoding uses the position held before any step/load this cycle.
    assign ntcv = dir ? (in_letter - {3'b000, rotor_pos})
                      : (in_letter + {3'b000, rotor_pos});

    letter_wrap u_wrap (
        .ntcv    (ntcv),
        .dir     (dir),
        .wrapped (wrapped)
    );

    assign enc_letter = letter_in ? wrapped : in_letter;

`ifdef ROTOR_DOUBLE_STEP_EN
    assign dbl_step = (rotor_pos == NOTCH);
`else
    assign dbl_step = 1'b0;
`endif

    assign step_req = accept && letter_in && (SELF_STEP || step_in || dbl_step);
    assign load_ok  = load_en && (load_pos < POS_W'(ALPHA_LEN));

    // Load wins over stepping; an out-of-range load leaves the position alone.
    always_comb begin
        pos_next = rotor_pos;
        if (load_en) begin
            if (load_ok) begin
                pos_next = load_pos;
            end
        end else if (step_req) begin
            if (rotor_pos == POS_W'(ALPHA_LEN - 1)) begin
                pos_next = '0;
            end else begin
                pos_next = rotor_pos + 1'b1;
            end
        end
    end

    assign carry_next = step_req && !load_en && (rotor_pos == NOTCH);

    // carry_out travels with its letter, so it is held through a stall.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_letter <= 8'h00;
            carry_out  <= 1'b0;
            rotor_pos  <= INIT_POS;
        end else begin
            rotor_pos <= pos_next;
            if (accept) begin
                out_valid  <= 1'b1;
                out_letter <= enc_letter;
                carry_out  <= carry_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                carry_out <= 1'b0;
            end
        end
    end

endmodule : rotor_shift_stage
`default_nettype wire

// File: tb/tb_rotor_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotor_shift_stage
// Description : Directed bench for rotor_shift_stage. Instance u_fast uses
//               SELF_STEP=1, instance u_slow uses default parameters; both
//               share the input stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotor_shift_stage;

    logic       clock = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_letter;
    logic       dir;
    logic       step_in;
    logic       load_en;
    logic [4:0] load_pos;
    logic       out_ready;

    logic       f_in_ready, f_out_valid, f_carry;
    logic [7:0] f_out_letter;
    logic [4:0] f_pos;
    logic       s_in_ready, s_out_valid, s_carry;
    logic [7:0] s_out_letter;
    logic [4:0] s_pos;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    rotor_shift_stage #(.SELF_STEP(1'b1)) u_fast (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_letter(in_letter),
        .dir(dir), .step_in(step_in), .load_en(load_en), .load_pos(load_pos),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_letter(f_out_letter),
        .carry_out(f_carry), .rotor_pos(f_pos)
    );

    rotor_shift_stage u_slow (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_letter(in_letter),
        .dir(dir), .step_in(step_in), .load_en(load_en), .load_pos(load_pos),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_letter(s_out_letter),
        .carry_out(s_carry), .rotor_pos(s_pos)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic d, input logic st);
        in_valid  = 1'b1;
        in_letter = ch;
        dir       = d;
        step_in   = st;
        tick();
        in_valid  = 1'b0;
        step_in   = 1'b0;
        load_en   = 1'b0;
    endtask

    task automatic load(input logic [4:0] p);
        load_en  = 1'b1;
        load_pos = p;
        tick();
        load_en  = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_letter = 8'h00;
        dir       = 1'b0;
        step_in   = 1'b0;
        load_en   = 1'b0;
        load_pos  = 5'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid",  int'(s_out_valid), 0);
        check("rst_out_letter", int'(s_out_letter), 0);
        check("rst_carry",      int'(s_carry), 0);
        check("rst_pos",        int'(s_pos), 0);
        resetn = 1'b1;
        tick();
        check("ready_after_rst", int'(f_in_ready), 1);

        // Fast rotor: 'A' x3 -> A, B, C; slow rotor stays at 0.
        send("A", 1'b0, 1'b0);
        check("fast_out0", int'(f_out_letter), 65);
        check("slow_out0", int'(s_out_letter), 65);
        send("A", 1'b0, 1'b0);
        check("fast_out1", int'(f_out_letter), 66);
        send("A", 1'b0, 1'b0);
        check("fast_out2", int'(f_out_letter), 67);
        check("fast_pos3", int'(f_pos), 3);
        check("slow_pos0", int'(s_pos), 0);

        // Forward overflow and position wrap 25 -> 0.
        load(5'd25);
        check("load25", int'(s_pos), 25);
        send("B", 1'b0, 1'b1);
        check("fwd_wrap_letter", int'(s_out_letter), 65);
        check("fwd_wrap_pos",    int'(s_pos), 0);
        check("fwd_wrap_carry",  int'(s_carry), 0);

        // Reverse underflow: 66 - 3 = 63 -> 89.
        load(5'd3);
        send("B", 1'b1, 1'b0);
        check("rev_wrap_letter", int'(s_out_letter), 89);
        check("rev_nostep_pos",  int'(s_pos), 3);

        // Notch: 'X'(88)+16 = 104 -> 78, carry with that output.
        load(5'd16);
        send("X", 1'b0, 1'b1);
        check("notch_letter", int'(s_out_letter), 78);
        check("notch_carry",  int'(s_carry), 1);
        check("notch_pos",    int'(s_pos), 17);
        load(5'd16);
        check("carry_cleared", int'(s_carry), 0);
        send("X", 1'b0, 1'b0);
        check("notch_nostep_letter", int'(s_out_letter), 78);
`ifdef ROTOR_DOUBLE_STEP_EN
        check("dbl_carry", int'(s_carry), 1);
        check("dbl_pos",   int'(s_pos), 17);
`else
        check("nostep_carry", int'(s_carry), 0);
        check("nostep_pos",   int'(s_pos), 16);
`endif

        // Stall: 'C'+5 = 'H', then 'D' held off for 4 cycles.
        load(5'd5);
        out_ready = 1'b0;
        send("C", 1'b0, 1'b1);
        check("stall_first_letter", int'(s_out_letter), 72);
        check("stall_first_pos",    int'(s_pos), 6);
        in_valid  = 1'b1;
        in_letter = "D";
        step_in   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_ready",  int'(s_in_ready), 0);
            check("stall_letter", int'(s_out_letter), 72);
            check("stall_pos",    int'(s_pos), 6);
            check("stall_valid",  int'(s_out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", int'(s_in_ready), 1);
        send("D", 1'b0, 1'b1);
        check("release_letter", int'(s_out_letter), 74);
        check("release_pos",    int'(s_pos), 7);
        send(" ", 1'b0, 1'b1);
        check("space_letter", int'(s_out_letter), 32);
        check("space_pos",    int'(s_pos), 7);
        check("space_carry",  int'(s_carry), 0);

        // Load together with acceptance: encode with old position 2.
        load(5'd2);
        load_en  = 1'b1;
        load_pos = 5'd7;
        send("A", 1'b0, 1'b1);
        check("ld_acc_letter", int'(s_out_letter), 67);
        check("ld_acc_pos",    int'(s_pos), 7);
        check("ld_acc_carry",  int'(s_carry), 0);
        load(5'd30);
        check("bad_load_pos", int'(s_pos), 7);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        send("B", 1'b0, 1'b0);
        check("pre_rst_letter", int'(s_out_letter), 73);
        tick();
        resetn = 1'b0;
        #1;
        check("midrst_valid",  int'(s_out_valid), 0);
        check("midrst_pos",    int'(s_pos), 0);
        check("midrst_letter", int'(s_out_letter), 0);
        tick();
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rotor_shift_stage
`default_nettype wire
